complex_op_sched: RTL and testbench
===================================

// Module: complex_op_sched
// PURPOSE
//  Shared-engine scheduler for the 8x32-bit complex-op mixing datapath.
//  Round-robin arbitrates NREQ requesters and loads the granted 8-word seed.
//  Runs the mixing round the requested number of times, one stage per cycle.
//  Returns the final state with the requester id. Sits between client blocks and one mixing engine.
// PARAMETERS
//  NREQ     4    number of requesters (2..8)
//  NSTAGE   5    stages per round (fixed by datapath, not overridable in practice)
// PORTS
//  clk         in   1          system clock, rising edge
//  rst_n       in   1          asynchronous active-low reset
//  req_valid   in   NREQ       request i presents seed/rounds
//  req_ready   out  NREQ       one-hot grant; transfer when valid&ready
//  req_seed    in   NREQ*256   seed of req i at [256*i+:256], word k at [32*k+:32]
//  req_rounds  in   NREQ*4     round count of req i; 0 encodes 16
//  rsp_valid   out  1          result available
//  rsp_ready   in   1          consumer accepts result
//  rsp_id      out  3          index of requester that owns result
//  rsp_data    out  256        final state, word k at [32*k+:32]
//  busy        out  1          engine not IDLE
// BEHAVIOUR
//  Reset: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, state=IDLE, rr pointer=0.
//  FSM: IDLE -> RUN on accept; RUN -> DONE after last stage; DONE -> IDLE on rsp_valid&rsp_ready.
//  IDLE: req_ready = one-hot of first valid requester at or after rr pointer (wrap-around), combinational.
//   On accept: state<=seed, rem<=rounds (0->16), stage<=0, id latched, rr pointer<=grant+1 mod NREQ.
//  RUN: req_ready=0. Each cycle applies stage[stage] to state; stage wraps 4->0 and rem decrements.
//   After stage 4 with rem==1: enter DONE. rsp_valid=1 and rsp_data=state from the next cycle.
//  Latency: accept at edge T -> rsp_valid high after edge T+5*R. R=1 gives 5 cycles; R=16 gives 80.
//  DONE: rsp_valid/rsp_id/rsp_data held stable until accepted. No new request is accepted while DONE.
//   Exit to IDLE on the accept edge. req_ready may assert on the following cycle (1 bubble).
//  Stage ops run in word order i=0..7, strictly sequential: word i sees words <i already updated.
//   Indices are mod 8. All arithmetic is 32-bit unsigned and wraps; >> is logical.
//   S0: s[i] = s[i] + i
//   S1: s[i] = s[i] + s[i-1]           (s[-1] is updated s[7]? no: old s[7], as 7 not yet updated)
//   S2: s[i] = s[i] ^ (s[i+3] << 16)
//   S3: s[i] = s[i] - (s[i+2] >> 17) + (s[i+4] >> 12)
//   S4: s[i] = s[i]*M[i] + C[i],  M={2,3,5,7,11,13,17,19}, C={3,5,7,11,13,17,19,23}
//  Requester deasserting req_valid without a grant is legal; that requester is skipped.
//  Changing req_seed without a grant is legal; only accept-edge values matter.
//  rst_n low mid-RUN/DONE aborts immediately to reset values; the job is lost and no response is made.
// STRUCTURE
//  complex_op_pkg: STATE_W=256, WORD_W=32, stage enum (ST_ADDC..ST_MUL), M/C constant arrays.
//  Sub-module complex_op_stage: combinational (state_in, stage) -> state_out, the 5 ops above.
//  complex_op_sched holds FSM, rr arbiter, round/stage counters, state and response registers.
// TESTING
//  1 Reset mid-RUN (rounds=16, drop rst_n at cycle 20) -> all outputs 0 at once; busy=0 and no rsp.
//  2 req0 seed=0, rounds=1, rsp_ready=1 -> rsp_valid exactly 5 cycles after accept, rsp_id=0.
//    rsp_data == golden C model; after S1 internal state is {7,8,10,13,17,22,28,35}.
//  3 rounds=0 (=16) on req2 -> rsp_valid 80 cycles after accept; data matches model of 16 rounds.
//  4 All 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one bubble between jobs.
//  5 rsp_ready=0 for 10 cycles in DONE -> rsp_data/rsp_id stable, req_ready all 0, then accept.
//  6 req1 valid only, then req3 raised while req1 in RUN -> req3 granted next; rr pointer = 2 after req1.

Source files
------------

// File: rtl/complex_op_pkg.sv
// Shared types and constants for the complex-op mixing scheduler and its stage datapath.
package complex_op_pkg;

  localparam int STATE_W = 256;
  localparam int WORD_W  = 32;
  localparam int NWORD   = STATE_W / WORD_W;

  typedef enum logic [2:0] {
    ST_ADDC   = 3'd0,
    ST_ADDP   = 3'd1,
    ST_XSH    = 3'd2,
    ST_SUBADD = 3'd3,
    ST_MUL    = 3'd4
  } stage_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sched_state_e;

  // Per-word multiplier and addend of the final stage
  localparam logic [WORD_W-1:0] MUL_K [NWORD] = '{
    32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19
  };
  localparam logic [WORD_W-1:0] ADD_K [NWORD] = '{
    32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23
  };

endpackage

// File: rtl/complex_op_stage.sv
// One combinational mixing stage over the 8-word state, selected by the stage index.
module complex_op_stage
  import complex_op_pkg::*;
(
  input  logic [STATE_W-1:0] state_in,
  input  stage_e             stage,
  output logic [STATE_W-1:0] state_out
);

  logic [WORD_W-1:0] w [NWORD];

  // Words are rewritten in place in index order, so word i sees words < i already updated.
  always_comb begin
    for (int k = 0; k < NWORD; k++) begin
      w[k] = state_in[WORD_W*k +: WORD_W];
    end
    for (int i = 0; i < NWORD; i++) begin
      case (stage)
        ST_ADDC:   w[i] = w[i] + WORD_W'(i);
        ST_ADDP:   w[i] = w[i] + w[(i + NWORD - 1) % NWORD];
        ST_XSH:    w[i] = w[i] ^ (w[(i + 3) % NWORD] << 16);
        ST_SUBADD: w[i] = w[i] - (w[(i + 2) % NWORD] >> 17) + (w[(i + 4) % NWORD] >> 12);
        ST_MUL:    w[i] = w[i] * MUL_K[i] + ADD_K[i];
        default:   w[i] = w[i];
      endcase
    end
    state_out = '0;
    for (int k = 0; k < NWORD; k++) begin
      state_out[WORD_W*k +: WORD_W] = w[k];
    end
  end

endmodule

// File: rtl/complex_op_sched.sv
// Round-robin scheduler feeding one mixing engine: grant, run R rounds of 5 stages, return result.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module complex_op_sched
  import complex_op_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int NSTAGE = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*STATE_W-1:0] req_seed,
  input  logic [NREQ*4-1:0]       req_rounds,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2:0]              rsp_id,
  output logic [STATE_W-1:0]      rsp_data,
  output logic                    busy,
  output sched_state_e            dbg_state
);

  localparam int     PTR_W      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam stage_e LAST_STAGE = stage_e'(3'(NSTAGE - 1));

  sched_state_e      state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, ptr_next;
  logic [NREQ-1:0]   grant_vec;
  logic [2:0]        grant_idx;
  logic              grant_any;
  logic              accept;
  logic              last_step;
  logic [STATE_W-1:0] acc_seed;
  logic [3:0]        acc_rounds;
  logic [STATE_W-1:0] st_q;
  logic [STATE_W-1:0] stage_out;
  logic [4:0]        rem_q;
  stage_e            stage_q;

  // First valid requester at or after the rotating pointer, wrapping around.
  always_comb begin
    grant_vec = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        grant_any = 1'b1;
        grant_idx = 3'((int'(rr_ptr_q) + k) % NREQ);
        grant_vec[(int'(rr_ptr_q) + k) % NREQ] = 1'b1;
      end
    end
  end

  always_comb begin
    acc_seed   = req_seed[STATE_W*grant_idx +: STATE_W];
    acc_rounds = req_rounds[4*grant_idx +: 4];
    ptr_next   = (int'(grant_idx) == NREQ - 1) ? '0 : PTR_W'(int'(grant_idx) + 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = rst_n ? grant_vec : '0;
        accept    = grant_any;
        if (grant_any) state_d = S_RUN;
      end
      S_RUN: begin
        last_step = (stage_q == LAST_STAGE) && (rem_q == 5'd1);
        if (last_step) state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  complex_op_stage u_stage (
    .state_in  (st_q),
    .stage     (stage_q),
    .state_out (stage_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= '0;
      rem_q     <= '0;
      stage_q   <= ST_ADDC;
      rr_ptr_q  <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (accept) begin
        st_q     <= acc_seed;
        rem_q    <= (acc_rounds == 4'd0) ? 5'd16 : {1'b0, acc_rounds};
        stage_q  <= ST_ADDC;
        rsp_id   <= grant_idx;
        rr_ptr_q <= ptr_next;
      end
      if (state_q == S_RUN) begin
        st_q <= stage_out;
        if (stage_q == LAST_STAGE) begin
          stage_q <= ST_ADDC;
          rem_q   <= 5'(rem_q - 5'd1);
        end else begin
          stage_q <= stage_e'(stage_q + 3'd1);
        end
      end
      if (last_step) begin
        rsp_valid <= 1'b1;
        rsp_data  <= stage_out;
      end
      if (state_q == S_DONE && rsp_ready) rsp_valid <= 1'b0;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_complex_op_sched.sv
// Self-checking bench for complex_op_sched: vector table plus hand-written arbitration/stall/reset sequences.
module tb_complex_op_sched;
  import complex_op_pkg::*;

  localparam int NREQ = 4;

  logic                    clk;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*256-1:0]     req_seed;
  logic [NREQ*4-1:0]       req_rounds;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [2:0]              rsp_id;
  logic [255:0]            rsp_data;
  logic                    busy;
  sched_state_e            dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [258:0] exp_q[$];
  logic [258:0] mon_e;

  complex_op_sched #(.NREQ(NREQ), .NSTAGE(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_seed   (req_seed),
    .req_rounds (req_rounds),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // golden model
  function automatic logic [255:0] model(input logic [255:0] seed, input logic [3:0] rounds);
    logic [31:0] s [8];
    logic [31:0] mk [8];
    logic [31:0] ck [8];
    logic [255:0] r;
    int n;
    mk = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
    ck = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
    n = (rounds == 4'd0) ? 16 : int'(rounds);
    for (int k = 0; k < 8; k++) s[k] = seed[32*k +: 32];
    for (int rr = 0; rr < n; rr++) begin
      for (int i = 0; i < 8; i++) s[i] = s[i] + 32'(i);
      for (int i = 0; i < 8; i++) s[i] = s[i] + s[(i + 7) % 8];
      for (int i = 0; i < 8; i++) s[i] = s[i] ^ (s[(i + 3) % 8] << 16);
      for (int i = 0; i < 8; i++) s[i] = s[i] - (s[(i + 2) % 8] >> 17) + (s[(i + 4) % 8] >> 12);
      for (int i = 0; i < 8; i++) s[i] = s[i] * mk[i] + ck[i];
    end
    r = '0;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = s[k];
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: compare every accepted response against the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id %0d expected no response", rsp_id);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", {253'd0, rsp_id}, {253'd0, mon_e[258:256]});
        chk("rsp_data", rsp_data, mon_e[255:0]);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [255:0] seed, input logic [3:0] r);
    req_valid[id]          = v;
    req_seed[256*id +: 256] = seed;
    req_rounds[4*id +: 4]  = r;
  endtask

  task automatic push_exp(input int id, input logic [255:0] seed, input logic [3:0] r);
    exp_q.push_back({3'(id), model(seed, r)});
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_seed   = '0;
    req_rounds = '0;
    rsp_ready  = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_grant(input logic [3:0] exp_vec, input string name);
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 200) begin
      tick();
      n++;
    end
    chk(name, {252'd0, req_ready}, {252'd0, exp_vec});
    tick();
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    chk(name, 256'(exp_q.size()), 256'd0);
  endtask

  typedef struct {
    int           id;
    logic [255:0] seed;
    logic [3:0]   rounds;
    int           lat;
  } vec_t;

  vec_t         vecs [6];
  logic [255:0] sd [4];
  int           lat;
  int           acc_cyc [5];
  int           seen;
  logic [3:0]   order_vec [5];
  int           order_id [5];

  initial begin
    vecs[0] = '{0, 256'd0, 4'd1, 5};
    vecs[1] = '{2, {8{32'h9E3779B9}}, 4'd0, 80};
    vecs[2] = '{1, {256{1'b1}}, 4'd3, 15};
    vecs[3] = '{3, {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210,
                    32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000001, 32'h80000000}, 4'd2, 10};
    vecs[4] = '{1, {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom}, 4'd4, 20};
    vecs[5] = '{0, {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom}, 4'd15, 75};
    for (int k = 0; k < 4; k++)
      sd[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 32'(k)};

    // reset state, with a request already pending
    rst_n      = 1'b0;
    rsp_ready  = 1'b0;
    req_valid  = 4'b1010;
    req_seed   = '0;
    req_rounds = '0;
    repeat (2) tick();
    chk("reset req_ready", {252'd0, req_ready}, 256'd0);
    chk("reset rsp_valid", {255'd0, rsp_valid}, 256'd0);
    chk("reset rsp_id", {253'd0, rsp_id}, 256'd0);
    chk("reset rsp_data", rsp_data, 256'd0);
    chk("reset busy", {255'd0, busy}, 256'd0);
    chk("reset state", {254'd0, dbg_state}, 256'd0);

    // single seed 0 job: latency, S1 intermediate, response
    do_reset();
    set_req(0, 1'b1, 256'd0, 4'd1);
    push_exp(0, 256'd0, 4'd1);
    wait_grant(4'b0001, "t2 grant");
    set_req(0, 1'b0, 256'd0, 4'd1);
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      tick();
      lat++;
      if (lat == 2)
        chk("t2 state after S1", dut.st_q,
            {32'd35, 32'd28, 32'd22, 32'd17, 32'd13, 32'd10, 32'd8, 32'd7});
    end
    chk("t2 latency", 256'(lat), 256'd5);
    chk("t2 busy in DONE", {255'd0, busy}, 256'd1);
    drain("t2 drain");

    // vector table, one requester at a time
    do_reset();
    for (int v = 0; v < 6; v++) begin
      set_req(vecs[v].id, 1'b1, vecs[v].seed, vecs[v].rounds);
      push_exp(vecs[v].id, vecs[v].seed, vecs[v].rounds);
      wait_grant(4'(1 << vecs[v].id), $sformatf("vec%0d grant", v));
      set_req(vecs[v].id, 1'b0, 256'd0, 4'd0);
      wait_rsp(lat);
      chk($sformatf("vec%0d latency", v), 256'(lat), 256'(vecs[v].lat));
      drain($sformatf("vec%0d drain", v));
    end

    // all four requesting continuously: 0,1,2,3,0 with one bubble between jobs
    do_reset();
    order_id = '{0, 1, 2, 3, 0};
    for (int g = 0; g < 5; g++) begin
      order_vec[g] = 4'(1 << order_id[g]);
      push_exp(order_id[g], sd[order_id[g]], 4'd1);
    end
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, sd[k], 4'd1);
    for (int g = 0; g < 5; g++) begin
      wait_grant(order_vec[g], $sformatf("t4 grant%0d", g));
      acc_cyc[g] = cyc;
      if (g > 0) chk($sformatf("t4 spacing%0d", g), 256'(acc_cyc[g] - acc_cyc[g-1]), 256'd7);
    end
    req_valid = '0;
    drain("t4 drain");

    // consumer stalls 10 cycles in DONE while another requester waits
    do_reset();
    rsp_ready = 1'b0;
    set_req(1, 1'b1, sd[1], 4'd2);
    push_exp(1, sd[1], 4'd2);
    wait_grant(4'b0010, "t5 grant");
    set_req(1, 1'b0, 256'd0, 4'd0);
    set_req(0, 1'b1, sd[0], 4'd1);
    wait_rsp(lat);
    chk("t5 latency", 256'(lat), 256'd10);
    for (int c = 0; c < 10; c++) begin
      chk("t5 hold valid", {255'd0, rsp_valid}, 256'd1);
      chk("t5 hold id", {253'd0, rsp_id}, 256'd1);
      chk("t5 hold data", rsp_data, model(sd[1], 4'd2));
      chk("t5 no grant", {252'd0, req_ready}, 256'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    #1;
    chk("t5 released valid", {255'd0, rsp_valid}, 256'd0);
    chk("t5 idle", {255'd0, busy}, 256'd0);
    drain("t5 drain");

    // pointer moves past req1, so req3 wins over req0
    do_reset();
    set_req(1, 1'b1, sd[1], 4'd2);
    push_exp(1, sd[1], 4'd2);
    wait_grant(4'b0010, "t6 grant req1");
    set_req(1, 1'b0, 256'd0, 4'd0);
    set_req(0, 1'b1, sd[0], 4'd1);
    set_req(3, 1'b1, sd[3], 4'd1);
    push_exp(3, sd[3], 4'd1);
    push_exp(0, sd[0], 4'd1);
    wait_grant(4'b1000, "t6 grant req3");
    set_req(3, 1'b0, 256'd0, 4'd0);
    wait_grant(4'b0001, "t6 grant req0");
    set_req(0, 1'b0, 256'd0, 4'd0);
    drain("t6 drain");

    // reset in the middle of a 16-round job
    do_reset();
    set_req(0, 1'b1, sd[2], 4'd0);
    wait_grant(4'b0001, "t1 grant");
    set_req(0, 1'b0, 256'd0, 4'd0);
    repeat (20) tick();
    chk("t1 busy before reset", {255'd0, busy}, 256'd1);
    req_valid[3] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t1 req_ready", {252'd0, req_ready}, 256'd0);
    chk("t1 rsp_valid", {255'd0, rsp_valid}, 256'd0);
    chk("t1 rsp_id", {253'd0, rsp_id}, 256'd0);
    chk("t1 rsp_data", rsp_data, 256'd0);
    chk("t1 busy", {255'd0, busy}, 256'd0);
    req_valid = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (rsp_valid || busy) seen++;
    end
    chk("t1 no response", 256'(seen), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
